// File: rtl/spi_flash_responder_if.sv
// ---------------------------------------------------------------------------
// spi_flash_responder_if
// Bundles the SPI target pins and the byte-wide memory port of
// spi_flash_responder.
//   cs_n, sclk, mosi   : SPI pins driven by the initiator
//   miso, miso_oe      : SPI return data and its output enable
//   mem_addr           : byte address presented to memory (ADDR_W bits)
//   mem_rd_req         : one-clk read strobe, mem_rdata valid on the next clk
//   mem_rdata          : read data from memory
//   mem_wr_req         : one-clk write strobe qualifying mem_addr/mem_wdata
//   mem_wdata          : write data to memory
//   wel                : write-enable latch state
// Modport slave is used by the responder, modport master by the initiator /
// memory side.
// ---------------------------------------------------------------------------
interface spi_flash_responder_if #(
    parameter int ADDR_W = 24
);
    logic              cs_n;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_req;
    logic [7:0]        mem_rdata;
    logic              mem_wr_req;
    logic [7:0]        mem_wdata;
    logic              wel;

    modport slave (
        input  cs_n, sclk, mosi, mem_rdata,
        output miso, miso_oe, mem_addr, mem_rd_req, mem_wr_req, mem_wdata, wel
    );

    modport master (
        output cs_n, sclk, mosi, mem_rdata,
        input  miso, miso_oe, mem_addr, mem_rd_req, mem_wr_req, mem_wdata, wel
    );
endinterface

// File: rtl/spi_flash_responder.sv
// ---------------------------------------------------------------------------
// spi_flash_responder
// SPI mode-0 target with a memory-side byte port. cs_n/sclk/mosi are
// oversampled in the clk domain; the command byte selects read (0x03),
// write (0x02), status (0x05), write-enable set (0x06) or clear (0x04).
// Ports:
//   clk  : system clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : spi_flash_responder_if.slave (SPI pins + memory port + wel)
// ---------------------------------------------------------------------------
module spi_flash_responder #(
    parameter int ADDR_W      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    spi_flash_responder_if.slave    bus
);

    localparam int         ADDR_BYTES = ADDR_W / 8;
    localparam logic [7:0] LAST_ABYTE = 8'(ADDR_BYTES - 1);

    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_WRITE  = 8'h02;
    localparam logic [7:0] OP_STATUS = 8'h05;
    localparam logic [7:0] OP_WREN   = 8'h06;
    localparam logic [7:0] OP_WRDI   = 8'h04;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CMD     = 4'd1,
        ST_ADDR    = 4'd2,
        ST_RD_WAIT = 4'd3,
        ST_RD      = 4'd4,
        ST_WR      = 4'd5,
        ST_STATUS  = 4'd6,
        ST_IGNORE  = 4'd7
    } state_t;

    // Status register image: only the write-enable latch is populated.
    function automatic logic [7:0] status_byte(input logic wel_bit);
        return {6'b000000, wel_bit, 1'b0};
    endfunction

    // Synchronizers plus one extra stage used for edge detection.
    logic [SYNC_STAGES-1:0] csn_sync_r;
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   csn_prev_r;
    logic                   sclk_prev_r;

    logic        csn_s;
    logic        sclk_s;
    logic        mosi_s;
    logic        cs_fall_s;
    logic        cs_rise_s;
    logic        sclk_rise_s;
    logic        sclk_fall_s;
    logic        byte_done_s;
    logic [7:0]  rx_byte_s;

    state_t              state_r;
    logic [2:0]          bit_cnt_r;
    logic [7:0]          rx_r;
    logic [7:0]          tx_r;
    logic [7:0]          addr_byte_r;
    logic                is_wr_r;
    logic                rd_pend_r;
    logic                miso_r;
    logic                miso_oe_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic                mem_rd_req_r;
    logic                mem_wr_req_r;
    logic [7:0]          mem_wdata_r;
    logic                wel_r;

    assign csn_s       = csn_sync_r[SYNC_STAGES-1];
    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
    assign cs_fall_s   = csn_prev_r & ~csn_s;
    assign cs_rise_s   = ~csn_prev_r & csn_s;
    assign sclk_rise_s = ~sclk_prev_r & sclk_s;
    assign sclk_fall_s = sclk_prev_r & ~sclk_s;
    assign byte_done_s = sclk_rise_s && (bit_cnt_r == 3'd7) && (state_r != ST_IDLE);
    assign rx_byte_s   = {rx_r[6:0], mosi_s};

    assign bus.miso       = miso_r;
    assign bus.miso_oe    = miso_oe_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_rd_req = mem_rd_req_r;
    assign bus.mem_wr_req = mem_wr_req_r;
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.wel        = wel_r;

    // Input synchronizers. cs_n resets low so a select already held low
    // across reset never looks like a fresh falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            csn_sync_r  <= '0;
            sclk_sync_r <= '0;
            mosi_sync_r <= '0;
            csn_prev_r  <= 1'b0;
            sclk_prev_r <= 1'b0;
        end else begin
            csn_sync_r  <= {csn_sync_r[SYNC_STAGES-2:0], bus.cs_n};
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], bus.sclk};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], bus.mosi};
            csn_prev_r  <= csn_s;
            sclk_prev_r <= sclk_s;
        end
    end

    // Protocol FSM with all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 3'd0;
            rx_r         <= 8'h00;
            tx_r         <= 8'h00;
            addr_byte_r  <= 8'h00;
            is_wr_r      <= 1'b0;
            rd_pend_r    <= 1'b0;
            miso_r       <= 1'b0;
            miso_oe_r    <= 1'b0;
            mem_addr_r   <= '0;
            mem_rd_req_r <= 1'b0;
            mem_wr_req_r <= 1'b0;
            mem_wdata_r  <= 8'h00;
            wel_r        <= 1'b0;
        end else begin
            mem_rd_req_r <= 1'b0;
            mem_wr_req_r <= 1'b0;
            // Memory answers one clk after the strobe; capture it then.
            rd_pend_r    <= mem_rd_req_r;
            if (rd_pend_r) begin
                tx_r <= bus.mem_rdata;
            end
            // Address advances after the write strobe so memory sees the old one.
            if (mem_wr_req_r) begin
                mem_addr_r <= mem_addr_r + ADDR_W'(1);
            end

            if (sclk_rise_s && (state_r != ST_IDLE)) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
                rx_r      <= rx_byte_s;
            end

            if (sclk_fall_s && ((state_r == ST_RD) || (state_r == ST_STATUS))) begin
                miso_r <= tx_r[7];
                tx_r   <= {tx_r[6:0], 1'b0};
            end

            case (state_r)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        state_r   <= ST_CMD;
                        bit_cnt_r <= 3'd0;
                    end
                end
                ST_CMD: begin
                    if (byte_done_s) begin
                        addr_byte_r <= 8'h00;
                        case (rx_byte_s)
                            OP_READ: begin
                                is_wr_r <= 1'b0;
                                state_r <= ST_ADDR;
                            end
                            OP_WRITE: begin
                                is_wr_r <= 1'b1;
                                state_r <= ST_ADDR;
                            end
                            OP_STATUS: begin
                                tx_r      <= status_byte(wel_r);
                                miso_oe_r <= 1'b1;
                                state_r   <= ST_STATUS;
                            end
                            OP_WREN: begin
                                wel_r   <= 1'b1;
                                state_r <= ST_IGNORE;
                            end
                            OP_WRDI: begin
                                wel_r   <= 1'b0;
                                state_r <= ST_IGNORE;
                            end
                            default: begin
                                state_r <= ST_IGNORE;
                            end
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise_s) begin
                        mem_addr_r <= {mem_addr_r[ADDR_W-2:0], mosi_s};
                        if (byte_done_s) begin
                            if (addr_byte_r == LAST_ABYTE) begin
                                if (is_wr_r) begin
                                    state_r <= ST_WR;
                                end else begin
                                    mem_rd_req_r <= 1'b1;
                                    state_r      <= ST_RD_WAIT;
                                end
                            end else begin
                                addr_byte_r <= addr_byte_r + 8'd1;
                            end
                        end
                    end
                end
                ST_RD_WAIT: begin
                    // First data byte lands in tx_r on this same clk.
                    if (rd_pend_r) begin
                        miso_oe_r <= 1'b1;
                        state_r   <= ST_RD;
                    end
                end
                ST_RD: begin
                    // Prefetch the next byte; it arrives well before the next fall.
                    if (byte_done_s) begin
                        mem_addr_r   <= mem_addr_r + ADDR_W'(1);
                        mem_rd_req_r <= 1'b1;
                    end
                end
                ST_WR: begin
                    if (byte_done_s && wel_r) begin
                        mem_wr_req_r <= 1'b1;
                        mem_wdata_r  <= rx_byte_s;
                    end
                end
                ST_STATUS: begin
                    if (byte_done_s) begin
                        tx_r <= status_byte(wel_r);
                    end
                end
                ST_IGNORE: begin
                    miso_r    <= 1'b0;
                    miso_oe_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase

            // Deselect wins over everything above except a byte completing
            // on this very clk, whose strobe has already been scheduled.
            if (cs_rise_s) begin
                state_r     <= ST_IDLE;
                miso_r      <= 1'b0;
                miso_oe_r   <= 1'b0;
                bit_cnt_r   <= 3'd0;
                rx_r        <= 8'h00;
                addr_byte_r <= 8'h00;
                is_wr_r     <= 1'b0;
                if (is_wr_r || ((state_r == ST_CMD) && byte_done_s && (rx_byte_s == OP_WRITE))) begin
                    wel_r <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_flash_responder
// Directed bench: drives SPI mode-0 transfers into spi_flash_responder and
// models a one-clk-latency byte memory that logs every strobe.
// ---------------------------------------------------------------------------
module tb_spi_flash_responder;

    localparam int ADDR_W = 24;
    localparam int H      = 8;   // sclk half period in clk cycles

    logic clk;
    logic rst;

    spi_flash_responder_if #(.ADDR_W(ADDR_W)) bus ();

    spi_flash_responder #(
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests;
    int n_fail;

    // Memory model, write/read logs and monitors.
    logic [7:0]        mem [0:4095];
    logic [ADDR_W-1:0] rd_log [$];
    logic [31:0]       wr_log [$];   // {addr[23:0], data}
    int                oe_cnt;
    int                both_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            mem[12'h010]   <= 8'hA5;
            mem[12'h011]   <= 8'h3C;
            mem[12'h012]   <= 8'hFF;
            mem[12'h013]   <= 8'h01;
            mem[12'hFFF]   <= 8'h5A;
            mem[12'h000]   <= 8'hC3;
            bus.mem_rdata  <= 8'h00;
        end else begin
            if (bus.mem_rd_req) begin
                bus.mem_rdata <= mem[bus.mem_addr[11:0]];
                rd_log.push_back(bus.mem_addr);
            end
            if (bus.mem_wr_req) begin
                mem[bus.mem_addr[11:0]] <= bus.mem_wdata;
                wr_log.push_back({bus.mem_addr, bus.mem_wdata});
            end
        end
        if (bus.miso_oe) oe_cnt <= oe_cnt + 1;
        if (bus.mem_rd_req && bus.mem_wr_req) both_cnt <= both_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b, input bit cs_with_rise, output logic r);
        bus.mosi = b;
        tick(H);
        r = bus.miso;
        bus.sclk = 1'b1;
        if (cs_with_rise) bus.cs_n = 1'b1;
        tick(H);
        bus.sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] d, input bit cs_last, output logic [7:0] q);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(d[i], cs_last && (i == 0), b);
            q[i] = b;
        end
    endtask

    task automatic send(input logic [7:0] d);
        logic [7:0] q;
        spi_byte(d, 1'b0, q);
    endtask

    task automatic cs_low();
        bus.cs_n = 1'b0;
        tick(H);
    endtask

    task automatic cs_high();
        tick(H);
        bus.cs_n = 1'b1;
        tick(2 * H);
    endtask

    task automatic check_reset_values(input string tag);
        n_tests++;
        if ({bus.miso, bus.miso_oe, bus.mem_rd_req, bus.mem_wr_req, bus.wel} !== 5'b00000) begin
            $display("FAIL %s ctrl: got miso/oe/rd/wr/wel=%b expected 00000", tag,
                     {bus.miso, bus.miso_oe, bus.mem_rd_req, bus.mem_wr_req, bus.wel});
            n_fail++;
        end
        n_tests++;
        if (bus.mem_addr !== 24'h000000) begin
            $display("FAIL %s mem_addr: got %h expected 000000", tag, bus.mem_addr);
            n_fail++;
        end
        n_tests++;
        if (bus.mem_wdata !== 8'h00) begin
            $display("FAIL %s mem_wdata: got %h expected 00", tag, bus.mem_wdata);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cs_n = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        tick(4);
        check_reset_values("reset");
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_read();
        logic [7:0] q;
        logic [7:0] exp_d [4];
        int base;
        exp_d = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
        base = rd_log.size();
        cs_low();
        send(8'h03); send(8'h00); send(8'h00); send(8'h10);
        for (int k = 0; k < 4; k++) begin
            spi_byte(8'h00, 1'b0, q);
            n_tests++;
            if (q !== exp_d[k]) begin
                $display("FAIL read_data[%0d]: got %h expected %h", k, q, exp_d[k]);
                n_fail++;
            end
        end
        n_tests++;
        if (bus.miso_oe !== 1'b1) begin
            $display("FAIL read_oe: got %b expected 1", bus.miso_oe);
            n_fail++;
        end
        cs_high();
        n_tests++;
        if (rd_log.size() < base + 4) begin
            $display("FAIL read_req_count: got %0d expected at least 4", rd_log.size() - base);
            n_fail++;
        end
        for (int k = 0; k < 4; k++) begin
            if (rd_log.size() > base + k) begin
                n_tests++;
                if (rd_log[base + k] !== 24'(24'h000010 + k)) begin
                    $display("FAIL read_addr[%0d]: got %h expected %h", k, rd_log[base + k],
                             24'(24'h000010 + k));
                    n_fail++;
                end
            end
        end
        n_tests++;
        if ({bus.miso_oe, bus.miso} !== 2'b00) begin
            $display("FAIL read_deselect: got oe/miso=%b expected 00", {bus.miso_oe, bus.miso});
            n_fail++;
        end
    endtask

    task automatic test_write();
        int base;
        cs_low(); send(8'h06); cs_high();
        n_tests++;
        if (bus.wel !== 1'b1) begin
            $display("FAIL wren: got wel=%b expected 1", bus.wel);
            n_fail++;
        end
        base = wr_log.size();
        cs_low();
        send(8'h02); send(8'h00); send(8'h01); send(8'h00); send(8'hDE); send(8'hAD);
        cs_high();
        n_tests++;
        if (wr_log.size() != base + 2) begin
            $display("FAIL write_count: got %0d expected 2", wr_log.size() - base);
            n_fail++;
        end else begin
            n_tests++;
            if (wr_log[base] !== 32'h000100DE || wr_log[base + 1] !== 32'h000101AD) begin
                $display("FAIL write_data: got %h %h expected 000100de 000101ad",
                         wr_log[base], wr_log[base + 1]);
                n_fail++;
            end
        end
        n_tests++;
        if (bus.wel !== 1'b0) begin
            $display("FAIL write_wel_clear: got wel=%b expected 0", bus.wel);
            n_fail++;
        end
    endtask

    task automatic test_wel_status();
        logic [7:0] q;
        int base;
        base = wr_log.size();
        cs_low();
        send(8'h02); send(8'h00); send(8'h00); send(8'h20); send(8'h77);
        cs_high();
        n_tests++;
        if (wr_log.size() != base) begin
            $display("FAIL write_no_wel: got %0d strobes expected 0", wr_log.size() - base);
            n_fail++;
        end
        cs_low(); send(8'h05); spi_byte(8'h00, 1'b0, q); cs_high();
        n_tests++;
        if (q !== 8'h00) begin
            $display("FAIL status_wel0: got %h expected 00", q);
            n_fail++;
        end
        cs_low(); send(8'h06); cs_high();
        cs_low(); send(8'h05);
        spi_byte(8'h00, 1'b0, q);
        n_tests++;
        if (q !== 8'h02) begin
            $display("FAIL status_wel1: got %h expected 02", q);
            n_fail++;
        end
        spi_byte(8'h00, 1'b0, q);
        n_tests++;
        if (q !== 8'h02) begin
            $display("FAIL status_repeat: got %h expected 02", q);
            n_fail++;
        end
        cs_high();
        cs_low(); send(8'h04); cs_high();
        n_tests++;
        if (bus.wel !== 1'b0) begin
            $display("FAIL wrdi: got wel=%b expected 0", bus.wel);
            n_fail++;
        end
    endtask

    task automatic test_wrap();
        logic [7:0] q0;
        logic [7:0] q1;
        int base;
        base = rd_log.size();
        cs_low();
        send(8'h03); send(8'hFF); send(8'hFF); send(8'hFF);
        spi_byte(8'h00, 1'b0, q0);
        spi_byte(8'h00, 1'b0, q1);
        cs_high();
        n_tests++;
        if (q0 !== 8'h5A || q1 !== 8'hC3) begin
            $display("FAIL wrap_data: got %h %h expected 5a c3", q0, q1);
            n_fail++;
        end
        n_tests++;
        if (rd_log.size() < base + 2) begin
            $display("FAIL wrap_count: got %0d expected at least 2", rd_log.size() - base);
            n_fail++;
        end else begin
            n_tests++;
            if (rd_log[base] !== 24'hFFFFFF || rd_log[base + 1] !== 24'h000000) begin
                $display("FAIL wrap_addr: got %h %h expected ffffff 000000",
                         rd_log[base], rd_log[base + 1]);
                n_fail++;
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] q;
        logic b;
        int base;
        cs_low(); send(8'h06); cs_high();
        base = wr_log.size();
        cs_low();
        send(8'h02); send(8'h00); send(8'h00); send(8'h40);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b0, b);
        cs_high();
        n_tests++;
        if (wr_log.size() != base) begin
            $display("FAIL abort_no_strobe: got %0d strobes expected 0", wr_log.size() - base);
            n_fail++;
        end
        n_tests++;
        if ({bus.wel, bus.miso_oe} !== 2'b00) begin
            $display("FAIL abort_state: got wel/oe=%b expected 00", {bus.wel, bus.miso_oe});
            n_fail++;
        end
        cs_low(); send(8'h05); spi_byte(8'h00, 1'b0, q); cs_high();
        n_tests++;
        if (q !== 8'h00) begin
            $display("FAIL abort_status: got %h expected 00", q);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q;
        int base;
        cs_low(); send(8'h06); cs_high();
        base = wr_log.size();
        cs_low();
        send(8'h02); send(8'h00); send(8'h02); send(8'h00); send(8'h11);
        // cs_n rises together with the final sclk rise of the second data byte.
        spi_byte(8'h22, 1'b1, q);
        tick(2 * H);
        n_tests++;
        if (wr_log.size() != base + 2) begin
            $display("FAIL b2b_count: got %0d expected 2", wr_log.size() - base);
            n_fail++;
        end else begin
            n_tests++;
            if (wr_log[base] !== 32'h00020011 || wr_log[base + 1] !== 32'h00020122) begin
                $display("FAIL b2b_data: got %h %h expected 00020011 00020122",
                         wr_log[base], wr_log[base + 1]);
                n_fail++;
            end
        end
        n_tests++;
        if (bus.wel !== 1'b0) begin
            $display("FAIL b2b_wel: got wel=%b expected 0", bus.wel);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] q;
        logic b;
        int rd_base;
        int wr_base;
        int oe_base;
        cs_low();
        send(8'h03); send(8'h00); send(8'h00); send(8'h10);
        spi_bit(1'b0, 1'b0, b);
        spi_bit(1'b0, 1'b0, b);
        n_tests++;
        if (bus.miso_oe !== 1'b1) begin
            $display("FAIL midrd_oe: got %b expected 1", bus.miso_oe);
            n_fail++;
        end
        rst = 1'b1;
        tick(1);
        check_reset_values("midrd_reset");
        rst = 1'b0;
        tick(4);
        rd_base = rd_log.size();
        wr_base = wr_log.size();
        oe_base = oe_cnt;
        // cs_n is still low: without a fresh fall nothing may happen.
        spi_byte(8'hFF, 1'b0, q);
        cs_high();
        cs_low();
        send(8'hAB);
        spi_byte(8'h00, 1'b0, q);
        cs_high();
        n_tests++;
        if (oe_cnt != oe_base) begin
            $display("FAIL unsup_oe: got %0d oe cycles expected 0", oe_cnt - oe_base);
            n_fail++;
        end
        n_tests++;
        if (rd_log.size() != rd_base || wr_log.size() != wr_base) begin
            $display("FAIL unsup_mem: got rd=%0d wr=%0d strobes expected 0 0",
                     rd_log.size() - rd_base, wr_log.size() - wr_base);
            n_fail++;
        end
        n_tests++;
        if (q !== 8'h00) begin
            $display("FAIL unsup_miso: got %h expected 00", q);
            n_fail++;
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        oe_cnt   = 0;
        both_cnt = 0;
        test_reset();
        test_read();
        test_write();
        test_wel_status();
        test_wrap();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        n_tests++;
        if (both_cnt != 0) begin
            $display("FAIL rd_wr_overlap: got %0d overlapping cycles expected 0", both_cnt);
            n_fail++;
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
